// File: rtl/spongent_sponge_ctrl_if.sv
// Stream, permutation and digest signals of the SPONGENT sponge controller.
// The controller connects through the slave modport and its environment through the master modport.
interface spongent_sponge_ctrl_if #(
  parameter int B = 88,
  parameter int R = 8
);
  localparam int NBW = $clog2(R) + 1;

  logic [R-1:0]   din;
  logic           din_valid;
  logic           din_last;
  logic [NBW-1:0] din_nbits;
  logic           din_ready;

  logic           perm_start;
  logic [B-1:0]   perm_state_o;
  logic [B-1:0]   perm_state_i;
  logic           perm_done;

  logic [R-1:0]   hash_out;
  logic           hash_valid;
  logic           hash_last;
  logic           hash_ready;

  logic           busy;

  modport slave (
    input  din, din_valid, din_last, din_nbits, perm_state_i, perm_done, hash_ready,
    output din_ready, perm_start, perm_state_o, hash_out, hash_valid, hash_last, busy
  );

  modport master (
    output din, din_valid, din_last, din_nbits, perm_state_i, perm_done, hash_ready,
    input  din_ready, perm_start, perm_state_o, hash_out, hash_valid, hash_last, busy
  );
endinterface

// File: rtl/spongent_sponge_ctrl.sv
// Sponge-mode controller for SPONGENT: absorbs padded R-bit blocks, sequences the
// permutation core over a start/done handshake, and squeezes HASH_BITS of digest.
module spongent_sponge_ctrl #(
  parameter int B         = 88,
  parameter int R         = 8,
  parameter int HASH_BITS = 88
) (
  input  logic                 clk,
  input  logic                 rst,
  spongent_sponge_ctrl_if.slave bus
);
  localparam int NBW = $clog2(R) + 1;
  localparam int NW  = HASH_BITS / R;
  localparam int KW  = $clog2(NW + 1);
  localparam logic [R-1:0] PAD_BLOCK = {1'b1, {(R-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PERM, S_PAD, S_SQUEEZE, S_PERM_SQ
  } fsm_t;

  fsm_t          r_fsm, w_fsm_nxt;
  logic [B-1:0]  r_state, w_state_nxt;
  logic          r_final, w_final_nxt;
  logic          r_pad_pending, w_pad_pending_nxt;
  logic          r_started, w_started_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic          r_live;

  // Final-word padding: keep the top din_nbits bits and append a single 1 below them.
  logic [NBW-1:0] w_shamt;
  logic [R-1:0]   w_keep, w_pad_bit, w_padded;
  logic           w_full_last, w_last_word;

  assign w_shamt     = NBW'(R) - bus.din_nbits;
  assign w_keep      = {R{1'b1}} << w_shamt;
  assign w_pad_bit   = PAD_BLOCK >> bus.din_nbits;
  assign w_padded    = (bus.din & w_keep) | w_pad_bit;
  assign w_full_last = (bus.din_nbits >= NBW'(R));
  assign w_last_word = (r_k == KW'(NW - 1));

  // NOTE: the state register is ordinary flop state, so it resets with the FSM; no
  // stale state may survive an aborted message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm         <= S_IDLE;
      r_state       <= '0;
      r_final       <= 1'b0;
      r_pad_pending <= 1'b0;
      r_started     <= 1'b0;
      r_k           <= '0;
      r_live        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_fsm         <= w_fsm_nxt;
      r_state       <= w_state_nxt;
      r_final       <= w_final_nxt;
      r_pad_pending <= w_pad_pending_nxt;
      r_started     <= w_started_nxt;
      r_k           <= w_k_nxt;
      r_live        <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value is defaulted first so no latch is inferred.
    w_fsm_nxt         = r_fsm;
    w_state_nxt       = r_state;
    w_final_nxt       = r_final;
    w_pad_pending_nxt = r_pad_pending;
    w_started_nxt     = r_started;
    w_k_nxt           = r_k;
    bus.din_ready     = 1'b0;
    bus.perm_start    = 1'b0;
    bus.hash_out      = '0;
    bus.hash_valid    = 1'b0;
    bus.hash_last     = 1'b0;
    bus.perm_state_o  = r_state;
    bus.busy          = (r_fsm != S_IDLE);

    unique case (r_fsm)
      S_IDLE, S_ABSORB: begin
        bus.din_ready = r_live;
        if (r_live && bus.din_valid) begin
          if (r_fsm == S_IDLE) begin
            w_final_nxt       = 1'b0;
            w_pad_pending_nxt = 1'b0;
          end
          if (!bus.din_last) begin
            w_state_nxt[R-1:0] = r_state[R-1:0] ^ bus.din;
          end else if (w_full_last) begin
            w_state_nxt[R-1:0] = r_state[R-1:0] ^ bus.din;
            w_pad_pending_nxt  = 1'b1;
          end else begin
            w_state_nxt[R-1:0] = r_state[R-1:0] ^ w_padded;
            w_final_nxt        = 1'b1;
          end
          w_started_nxt = 1'b0;
          w_fsm_nxt     = S_PERM;
        end
      end

      // A done pulse only counts once this visit has issued its start pulse.
      S_PERM, S_PERM_SQ: begin
        if (!r_started) begin
          bus.perm_start = 1'b1;
          w_started_nxt  = 1'b1;
        end else if (bus.perm_done) begin
          w_state_nxt   = bus.perm_state_i;
          w_started_nxt = 1'b0;
          if (r_fsm == S_PERM_SQ) w_fsm_nxt = S_SQUEEZE;
          else if (r_pad_pending) w_fsm_nxt = S_PAD;
          else if (r_final)       w_fsm_nxt = S_SQUEEZE;
          else                    w_fsm_nxt = S_ABSORB;
        end
      end

      S_PAD: begin
        w_state_nxt[R-1:0] = r_state[R-1:0] ^ PAD_BLOCK;
        w_pad_pending_nxt  = 1'b0;
        w_final_nxt        = 1'b1;
        w_started_nxt      = 1'b0;
        w_fsm_nxt          = S_PERM;
      end

      S_SQUEEZE: begin
        bus.hash_valid = 1'b1;
        bus.hash_out   = r_state[R-1:0];
        bus.hash_last  = w_last_word;
        if (bus.hash_ready) begin
          if (w_last_word) begin
            w_state_nxt = '0;
            w_k_nxt     = '0;
            w_final_nxt = 1'b0;
            w_fsm_nxt   = S_IDLE;
          end else begin
            w_k_nxt       = r_k + KW'(1);
            w_started_nxt = 1'b0;
            w_fsm_nxt     = S_PERM_SQ;
          end
        end
      end

      default: w_fsm_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_spongent_sponge_ctrl.sv
// Directed bench for spongent_sponge_ctrl with an identity (or rotate-left) permutation
// stub that answers perm_start with perm_done three cycles later.
module tb_spongent_sponge_ctrl;
  localparam int B  = 88;
  localparam int R  = 8;
  localparam int HB = 88;
  localparam int NW = HB / R;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spongent_sponge_ctrl_if #(.B(B), .R(R)) bus ();

  spongent_sponge_ctrl #(.B(B), .R(R), .HASH_BITS(HB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Permutation stub
  logic [2:0]   sh       = '0;
  logic         inj_done = 1'b0;
  logic [B-1:0] inj_val  = '0;
  logic         rot_mode = 1'b0;

  always @(posedge clk) sh <= {sh[1:0], bus.perm_start};
  assign bus.perm_done    = sh[2] | inj_done;
  assign bus.perm_state_i = inj_done ? inj_val :
                            rot_mode ? {bus.perm_state_o[B-2:0], bus.perm_state_o[B-1]} :
                                       bus.perm_state_o;

  int n_perm = 0;
  int n_viol = 0;
  int cyc    = 0;
  bit outst  = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.perm_start) begin
      n_perm <= n_perm + 1;
      if (outst) n_viol <= n_viol + 1;
      outst <= 1'b1;
    end else if (bus.perm_done) begin
      outst <= 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offers one word at a negedge; returns the cycle number of the handshake.
  task automatic send_word(input logic [7:0] d, input bit last, input logic [3:0] nb,
                           output int t_hs);
    int waited;
    bus.din       = d;
    bus.din_last  = last;
    bus.din_nbits = nb;
    bus.din_valid = 1'b1;
    waited = 0;
    while (!bus.din_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.din_ready) check("din_ready_timeout", 0, 1);
    t_hs = cyc;
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic get_digest(input string name, input logic [7:0] exp_w [NW],
                            input int stall_k, input int t_hs, input int exp_lat);
    int   waited;
    int   p0;
    bit   stable;
    for (int k = 0; k < NW; k++) begin
      if (k == stall_k) bus.hash_ready = 1'b0;
      waited = 0;
      while (!bus.hash_valid && waited < 60) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.hash_valid) check({name, "_hash_valid_timeout"}, 0, 1);
      if (k == 0 && exp_lat > 0) check({name, "_latency"}, cyc - t_hs, exp_lat);
      check({name, "_word"}, bus.hash_out, exp_w[k]);
      check({name, "_last"}, bus.hash_last, (k == NW - 1));
      if (k == stall_k) begin
        p0     = n_perm;
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!bus.hash_valid || bus.hash_out !== exp_w[k] || bus.hash_last !== 1'b0)
            stable = 1'b0;
        end
        check({name, "_stall_hold"}, stable, 1);
        check({name, "_stall_noperm"}, n_perm - p0, 0);
        bus.hash_ready = 1'b1;
      end
      @(negedge clk);
    end
    check({name, "_busy_after"}, bus.busy, 0);
    check({name, "_state_cleared"}, bus.perm_state_o, 0);
  endtask

  logic [7:0] exp_w [NW];
  logic [7:0] rot_tbl [NW];
  int t_hs;
  int p0;

  initial begin
    bus.din = '0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.din_nbits = '0;
    bus.hash_ready = 1'b1;
    rot_tbl = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state
    #1;
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_perm_start", bus.perm_start, 0);
    check("rst_hash_valid", bus.hash_valid, 0);
    check("rst_hash_out", bus.hash_out, 0);
    check("rst_state", bus.perm_state_o, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single full word 0xA5: PAD block follows, rate 0x25
    p0 = n_perm;
    send_word(8'hA5, 1'b1, 4'd8, t_hs);
    check("t1_start_pulse", bus.perm_start, 1);
    check("t1_no_ready_in_perm", bus.din_ready, 0);
    check("t1_busy", bus.busy, 1);
    foreach (exp_w[i]) exp_w[i] = 8'h25;
    get_digest("t1", exp_w, -1, t_hs, 0);
    check("t1_perm_count", n_perm - p0, 12);

    // Partial word 0xA0 / 4 bits: padded block 0xA8, din_valid noise while busy
    p0 = n_perm;
    send_word(8'hA0, 1'b1, 4'd4, t_hs);
    bus.din = 8'hFF; bus.din_last = 1'b1; bus.din_nbits = 4'd8; bus.din_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.din_valid = 1'b0; bus.din_last = 1'b0;
    foreach (exp_w[i]) exp_w[i] = 8'hA8;
    get_digest("t2", exp_w, -1, t_hs, 5);
    check("t2_perm_count", n_perm - p0, 11);

    // Two words 0x01, 0x02: rate 0x03 then pad to 0x83
    p0 = n_perm;
    send_word(8'h01, 1'b0, 4'd8, t_hs);
    send_word(8'h02, 1'b1, 4'd8, t_hs);
    check("t3_rate_before_pad", bus.perm_state_o, 88'h03);
    foreach (exp_w[i]) exp_w[i] = 8'h83;
    get_digest("t3", exp_w, -1, t_hs, 0);
    check("t3_perm_count", n_perm - p0, 13);

    // Back-pressure on digest word 3
    p0 = n_perm;
    send_word(8'hA0, 1'b1, 4'd4, t_hs);
    foreach (exp_w[i]) exp_w[i] = 8'hA8;
    get_digest("t4", exp_w, 2, t_hs, 5);
    check("t4_perm_count", n_perm - p0, 11);

    // Reset during the second permutation, then a late perm_done
    send_word(8'h01, 1'b0, 4'd8, t_hs);
    send_word(8'h02, 1'b1, 4'd8, t_hs);
    check("t5_second_start", bus.perm_start, 1);
    rst = 1'b0;
    #1;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_perm_start", bus.perm_start, 0);
    check("t5_rst_din_ready", bus.din_ready, 0);
    check("t5_rst_state", bus.perm_state_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    p0 = n_perm;
    repeat (8) @(negedge clk);
    inj_val  = {B{1'b1}};
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    check("t5_late_done_busy", bus.busy, 0);
    check("t5_late_done_state", bus.perm_state_o, 0);
    check("t5_late_done_hash_valid", bus.hash_valid, 0);
    check("t5_no_spurious_start", n_perm - p0, 0);
    p0 = n_perm;
    send_word(8'hA0, 1'b1, 4'd4, t_hs);
    foreach (exp_w[i]) exp_w[i] = 8'hA8;
    get_digest("t5", exp_w, -1, t_hs, 5);
    check("t5_perm_count", n_perm - p0, 11);

    // Rotate-left-by-1 stub: squeezed words follow the rotated state
    rot_mode = 1'b1;
    p0 = n_perm;
    send_word(8'h01, 1'b1, 4'd8, t_hs);
    get_digest("t6", rot_tbl, -1, t_hs, 0);
    check("t6_perm_count", n_perm - p0, 12);
    rot_mode = 1'b0;

    check("perm_start_overlap", n_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
